mul_unit: RTL and testbench

- Iterative two's-complement multiplier that executes the MUL opcode (IR[15:12] = 4'b1101).
- The control unit's MUL execute state asserts Start and waits for Done. Product is then gated onto the bus and loaded into DR with setCC.
- Uses a radix-2 shift-add algorithm on operand magnitudes, followed by a sign fix-up. It sits alongside the ALU in the datapath.

---
 rtl/lc3_pkg.sv | 16 +
 rtl/mul_unit.sv | 132 +++++++++++++
 tb/tb_mul_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath definitions.
//   mul_state_t : control states of the iterative multiplier
//   LC3_WORD_W  : machine word width (default multiplier operand width)
//   OP_MUL      : IR[15:12] encoding of the MUL opcode
package lc3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int         LC3_WORD_W = 16;
    localparam logic [3:0] OP_MUL     = 4'b1101;

endpackage

// File: rtl/mul_unit.sv
// Iterative two's-complement multiplier for the LC-3 MUL opcode.
// Radix-2 shift-add over operand magnitudes, then a sign fix-up. The
// control unit pulses Start and waits for Done; Product is then gated to
// the bus and written into DR with setCC.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   Start      in   request, sampled only in IDLE or DONE
//   Operand_A  in   WIDTH  multiplicand (two's complement)
//   Operand_B  in   WIDTH  multiplier   (two's complement)
//   Product    out  WIDTH  low WIDTH bits of the signed product (registered)
//   Busy       out  high while in RUN
//   Done       out  one-cycle pulse when Product becomes valid
//   Overflow   out  full product does not fit in signed WIDTH (held)
//
// Build option:
//   MUL_EARLY_EXIT_EN  leave RUN as soon as the remaining multiplier
//                      magnitude is zero; results are identical, only the
//                      latency shrinks.
module mul_unit
    import lc3_pkg::*;
#(
    parameter int WIDTH = LC3_WORD_W
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    output logic [WIDTH-1:0] Product,
    output logic             Busy,
    output logic             Done,
    output logic             Overflow
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // Largest positive magnitude representable in signed WIDTH bits.
    localparam logic [2*WIDTH-1:0] POS_LIM = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    // Largest negative magnitude (one more than POS_LIM).
    localparam logic [2*WIDTH-1:0] NEG_LIM = POS_LIM + 1'b1;

    // Magnitude as an unsigned value; the most negative input maps onto
    // itself, which is exactly its magnitude when read unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : v;
    endfunction

    function automatic logic out_of_range(input logic [2*WIDTH-1:0] mag, input logic is_neg);
        return is_neg ? (mag > NEG_LIM) : (mag > POS_LIM);
    endfunction

    mul_state_t state, state_next;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg;
    logic [CNT_W-1:0]   count;

    logic                      accept;
    logic                      run_last;
    logic [2*WIDTH-1:0]        acc_sum;
    logic signed [2*WIDTH-1:0] result;

    assign accept = Start && ((state == IDLE) || (state == DONE));

    // The last partial product is folded in on the same edge that leaves
    // RUN, so the fix-up works on the post-add accumulator.
    assign acc_sum = acc + (mag_b[0] ? mag_a : '0);
    assign result  = neg ? -$signed(acc_sum) : $signed(acc_sum);

`ifdef MUL_EARLY_EXIT_EN
    // Nothing left to add once the shifted multiplier is zero.
    assign run_last = (count == LAST) || (mag_b[WIDTH-1:1] == '0);
`else
    assign run_last = (count == LAST);
`endif

    // ---- control: state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = RUN;
            RUN:     if (run_last) state_next = DONE;
            DONE:    state_next = Start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign Busy = (state == RUN);
    assign Done = (state == DONE);

    // ---- datapath: operand latch, shift-add iteration, result capture
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            acc      <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            neg      <= 1'b0;
            count    <= '0;
            Product  <= '0;
            Overflow <= 1'b0;
        end else if (accept) begin
            acc   <= '0;
            mag_a <= {{WIDTH{1'b0}}, magnitude(Operand_A)};
            mag_b <= magnitude(Operand_B);
            neg   <= Operand_A[WIDTH-1] ^ Operand_B[WIDTH-1];
            count <= '0;
        end else if (state == RUN) begin
            acc   <= acc_sum;
            mag_a <= mag_a << 1;
            mag_b <= mag_b >> 1;
            count <= count + 1'b1;
            if (run_last) begin
                Product  <= result[WIDTH-1:0];
                Overflow <= out_of_range(acc_sum, neg);
            end
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// Testbench for mul_unit: scoreboard of expected results (product,
// overflow, completion cycle, busy length) checked by an independent
// monitor whenever Done is seen. Honours MUL_EARLY_EXIT_EN for latency.
module tb_mul_unit;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] p;
        logic         ovf;
        int           run;
        int           done_edge;
    } exp_t;

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         Start = 1'b0;
    logic [W-1:0] Operand_A = '0;
    logic [W-1:0] Operand_B = '0;
    logic [W-1:0] Product;
    logic         Busy;
    logic         Done;
    logic         Overflow;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    exp_t sbq[$];

    mul_unit #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Operand_A (Operand_A),
        .Operand_B (Operand_B),
        .Product   (Product),
        .Busy      (Busy),
        .Done      (Done),
        .Overflow  (Overflow)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer multiply, range test, and the number of
    // multiplier bits that need processing.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int e0);
        exp_t   r;
        longint sa, sb, full, mb;
        int     n;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        full = sa * sb;
        r.p   = full[W-1:0];
        r.ovf = (full > 32767) || (full < -32768);
        mb = (sb < 0) ? -sb : sb;
        n  = 0;
        while (mb > 0) begin
            n++;
            mb = mb >>> 1;
        end
`ifdef MUL_EARLY_EXIT_EN
        r.run = (n < 1) ? 1 : n;
`else
        r.run = W;
`endif
        r.done_edge = e0 + r.run;
        return r;
    endfunction

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                busy_cnt = 0;
            end else begin
                check("busy_and_done_exclusive", {31'd0, Busy & Done}, 32'd0);
                if (Busy) busy_cnt++;
                if (Done) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        check("product", {16'd0, Product}, {16'd0, e.p});
                        check("overflow", {31'd0, Overflow}, {31'd0, e.ovf});
                        check("done_cycle", cyc, e.done_edge);
                        check("busy_cycles", busy_cnt, e.run);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    // Wait for the unit to be able to accept, then present a one-cycle Start.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge Clk);
        while (Busy && n < 100) begin
            n++;
            @(negedge Clk);
        end
        if (Busy) check("issue_wait_timeout", 32'd1, 32'd0);
        Operand_A = a;
        Operand_B = b;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        sbq.push_back(model(a, b, cyc));
        @(negedge Clk);
        Start = 1'b0;
        Operand_A = W'($urandom);
        Operand_B = W'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            n++;
            @(negedge Clk);
        end
        if (sbq.size() != 0) begin
            check("drain_timeout", sbq.size(), 32'd0);
            sbq.delete();
        end
        @(negedge Clk);
    endtask

    logic [W-1:0] da[7] = '{16'd3, 16'hFFFC, 16'hFFFF, 16'd300, 16'h8000, 16'h0000, 16'h8000};
    logic [W-1:0] db[7] = '{16'd5, 16'd7,    16'hFFFF, 16'd300, 16'hFFFF, 16'h1234, 16'h8000};

    initial begin
        exp_t         m;
        logic [W-1:0] prev_p;
        logic [W-1:0] a, b;
        int           pushed, n;
        logic         pend;

        // Reset state
        repeat (2) @(negedge Clk);
        check("reset_product", {16'd0, Product}, 32'd0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_done", {31'd0, Done}, 32'd0);
        check("reset_overflow", {31'd0, Overflow}, 32'd0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Directed operand pairs; Product must hold the previous result
        // while the next multiply runs.
        prev_p = '0;
        for (int i = 0; i < 7; i++) begin
            issue(da[i], db[i]);
            check("product_hold", {16'd0, Product}, {16'd0, prev_p});
            m = model(da[i], db[i], 0);
            prev_p = m.p;
            drain();
        end

        // Reset during RUN abandons the operation
        issue(16'd3, 16'd5);
        repeat (4) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("midrun_reset_product", {16'd0, Product}, 32'd0);
        check("midrun_reset_overflow", {31'd0, Overflow}, 32'd0);
        check("midrun_reset_busy", {31'd0, Busy}, 32'd0);
        check("midrun_reset_done", {31'd0, Done}, 32'd0);
        sbq.delete();
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (25) @(negedge Clk);
        issue(16'd3, 16'd5);
        drain();

        // Random single requests with random gaps
        for (int i = 0; i < 30; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 2) == 0) b = W'($urandom_range(0, 40)) - 16'd20;
            if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 255));
            issue(a, b);
            repeat ($urandom_range(0, 3)) @(negedge Clk);
        end
        drain();

        // Start held high, operands changing every cycle
        pushed = 0;
        n = 0;
        while (pushed < 8 && n < 400) begin
            n++;
            @(negedge Clk);
            Start = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            Operand_A = a;
            Operand_B = b;
            pend = !Busy;
            @(posedge Clk);
            #1;
            if (pend) begin
                sbq.push_back(model(a, b, cyc));
                pushed++;
            end
        end
        check("backtoback_accepts", pushed, 32'd8);
        @(negedge Clk);
        Start = 1'b0;
        drain();
        repeat (3) @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
